iter_serial_engine: RTL
=======================

ITER_SERIAL_ENGINE -- requirements
Module: iter_serial_engine

Interface
REQ-001 Parameter: WIDTH, default 8, operand bit count (range 2..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request new operation; sampled only in IDLE.
REQ-005 Port: dir  input  1  bit order; 0 = LSB first, 1 = MSB first; sampled with start.
REQ-006 Port: x  input  WIDTH  operand word; sampled with start.
REQ-007 Port: p_init  input  1  initial P value; sampled with start.
REQ-008 Port: q_init  input  1  initial Q value; sampled with start.
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse; result valid.
REQ-011 Port: p_out  output  1  final P; held until next accepted start.
REQ-012 Port: q_out  output  1  final Q; held until next accepted start.

Function
REQ-013 One iteration step with bit b: P' = b ? Q : P; Q' = !b | (P & Q).
REQ-014 FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after WIDTH steps; DONE->IDLE unconditionally.
REQ-015 Start acceptance (IDLE, start=1): latch x, dir, P=p_init, Q=q_init, step counter=0.
REQ-016 RUN: exactly one step per cycle, bit index = counter (dir=0) or WIDTH-1-counter (dir=1); counter increments per step.
REQ-017 Latency: start accepted at edge 0 -> busy high cycles 1..WIDTH -> done high cycle WIDTH+1 only.
REQ-018 p_out/q_out update at entry to DONE; unchanged in IDLE and RUN.
REQ-019 start while in RUN or DONE ignored; no queuing; operands not re-sampled.
REQ-020 Changes on x/dir/p_init/q_init after acceptance have no effect on the running operation.
REQ-021 Counter width clog2(WIDTH+1); no wrap during a legal operation.
REQ-022 Back-to-back: start high continuously -> new operation accepted in the IDLE cycle after DONE (period WIDTH+2).

Reset
REQ-023 rst_n=0 at an edge: state=IDLE, counter=0, P=Q=0, busy=0, done=0, p_out=0, q_out=0.
REQ-024 Reset mid-RUN or in DONE aborts the operation; no done pulse; start accepted on first edge with rst_n=1.

Configuration
REQ-025 Macro ITER_CHAIN_EN adds input port chain (1 bit, sampled with start).
REQ-026 With ITER_CHAIN_EN: start with chain=1 initialises P,Q from current p_out,q_out instead of p_init,q_init (multi-word chaining); chain=0 behaves as REQ-015.
REQ-027 Without ITER_CHAIN_EN: port chain absent; initial values always from p_init,q_init.

Structure
REQ-028 Shared package holds FSM state encodings (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-029 One sub-module iter_step: combinational single step (b, P, Q -> P', Q') per REQ-013, instantiated once.

Verification
REQ-030 WIDTH=4, x=4'b0000, p_init=0, q_init=0, dir=0 -> done at cycle 5, p_out=0, q_out=1.
REQ-031 WIDTH=4, x=4'b1111, p_init=1, q_init=0, dir=0 -> p_out=0, q_out=0; busy high exactly 4 cycles.
REQ-032 WIDTH=4, x=4'b1000, p_init=1, q_init=0: dir=0 -> (1,1); dir=1 -> (0,1).
REQ-033 rst_n low for one cycle during RUN step 2 -> no done, all outputs 0; next start completes normally.
REQ-034 start pulsed during RUN and DONE -> ignored; exactly one done per accepted start.
REQ-035 ITER_CHAIN_EN: after result (0,1), start chain=1, x=4'b1111, dir=0 -> p_out=0, q_out=0.

Source files
------------

// File: rtl/iter_serial_engine_pkg.sv
// Shared definitions for the iterative serial P/Q engine: FSM encoding and default operand width.
package iter_serial_engine_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iter_step.sv
// Combinational single iteration: P' = b ? Q : P, Q' = !b | (P & Q).
module iter_step (
  input  logic b,
  input  logic p,
  input  logic q,
  output logic p_nxt,
  output logic q_nxt
);

  assign p_nxt = b ? q : p;
  assign q_nxt = ~b | (p & q);

endmodule

// File: rtl/iter_serial_engine.sv
// Serial engine folding WIDTH operand bits through iter_step, one bit per cycle.
// Optional macro ITER_CHAIN_EN adds a chain input that seeds P/Q from the previous result.
module iter_serial_engine
  import iter_serial_engine_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] x,
  input  logic             p_init,
  input  logic             q_init,
`ifdef ITER_CHAIN_EN
  input  logic             chain,
`endif
  output logic             busy,
  output logic             done,
  output logic             p_out,
  output logic             q_out,
  output state_t           state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  // Handshake: start is a request sampled only in IDLE (no ready, no queuing);
  // done is a one-cycle completion strobe, p_out/q_out hold the result until the next accept.
  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] x_q;
  logic             dir_q;
  logic             p_q, q_q;
  logic             b, p_nxt, q_nxt;
  logic             p_seed, q_seed;
  logic             accept, last_step;

  assign accept    = (state == IDLE) && start;
  assign last_step = (state == RUN) && (cnt == CW'(WIDTH - 1));

`ifdef ITER_CHAIN_EN
  assign p_seed = chain ? p_out : p_init;
  assign q_seed = chain ? q_out : q_init;
`else
  assign p_seed = p_init;
  assign q_seed = q_init;
`endif

  // The operand is shifted toward the consumed end, so the current bit is always at a fixed edge.
  assign b = dir_q ? x_q[WIDTH-1] : x_q[0];

  iter_step u_step (
    .b     (b),
    .p     (p_q),
    .q     (q_q),
    .p_nxt (p_nxt),
    .q_nxt (q_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_step) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      x_q   <= '0;
      dir_q <= 1'b0;
      p_q   <= 1'b0;
      q_q   <= 1'b0;
      p_out <= 1'b0;
      q_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        x_q   <= x;
        dir_q <= dir;
        p_q   <= p_seed;
        q_q   <= q_seed;
        cnt   <= '0;
      end else if (state == RUN) begin
        x_q <= dir_q ? (x_q << 1) : (x_q >> 1);
        p_q <= p_nxt;
        q_q <= q_nxt;
        cnt <= cnt + CW'(1);
        if (last_step) begin
          p_out <= p_nxt;
          q_out <= q_nxt;
        end
      end
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule
